// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl shared package: geometry constants, FSM states,
// fifo2 sizing and bit-reversal helpers.
package ntt_ctrl_pkg;

    localparam int NTT_STAGE_CNT       = 8;
    localparam int DATA_WIDTH          = 16;
    localparam int MUL_STAGE_CNT       = 6;
    localparam int MUL_STAGE_BITS      = 3;
    localparam int MAX_FIFO2_ADDR_BITS = 6;
    localparam int PW                  = NTT_STAGE_CNT - 1;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Reorder-FIFO depth of stage i (half-span vs multiplier latency).
    function automatic int fifo2_size(input int i);
        int hrs;
        hrs = 1 << (NTT_STAGE_CNT - i - 1);
        if (hrs > MUL_STAGE_CNT)
            return hrs - MUL_STAGE_CNT - 1;
        else
            return MUL_STAGE_CNT - hrs - 1;
    endfunction

    function automatic logic [PW-1:0] bitrev(input logic [PW-1:0] x);
        logic [PW-1:0] r;
        for (int b = 0; b < PW; b++)
            r[b] = x[PW-1-b];
        return r;
    endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl bus: command, source RAM, ntt pipe, destination RAM
// and FIFO address signals. master = controller side.
interface ntt_ctrl_if;
    import ntt_ctrl_pkg::*;

    logic                                       start;
    logic                                       busy;
    logic                                       done;
    logic                                       err;
    logic                                       src_rd_en;
    logic [PW-1:0]                              src_addr;
    logic [2*DATA_WIDTH-1:0]                    src_data;
    logic                                       ntt_in_en;
    logic [2*DATA_WIDTH-1:0]                    ntt_in;
    logic                                       ntt_out_en;
    logic [2*DATA_WIDTH-1:0]                    ntt_out;
    logic                                       dst_wr_en;
    logic [PW-1:0]                              dst_addr;
    logic [2*DATA_WIDTH-1:0]                    dst_data;
    logic [MUL_STAGE_BITS-1:0]                  fifom_addr;
    logic [NTT_STAGE_CNT*MAX_FIFO2_ADDR_BITS-1:0] fifo2_addr;

    modport master (
        input  start, src_data, ntt_out_en, ntt_out,
        output busy, done, err, src_rd_en, src_addr,
        output ntt_in_en, ntt_in, dst_wr_en, dst_addr,
        output dst_data, fifom_addr, fifo2_addr
    );

    modport slave (
        output start, src_data, ntt_out_en, ntt_out,
        input  busy, done, err, src_rd_en, src_addr,
        input  ntt_in_en, ntt_in, dst_wr_en, dst_addr,
        input  dst_data, fifom_addr, fifo2_addr
    );

endinterface

// File: rtl/ntt_ctrl_mod_cnt.sv
// mod_cnt: wrapping counter 0..MOD-1 with sync clear and enable.
// Ports: clk, rst (async high), clr, en, q. MOD<=1 holds q at 0.
module mod_cnt #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] LAST =
        (MOD <= 1) ? '0 : W'(MOD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= (q == LAST) ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: feeds one polynomial into ntt, collects results, drives
// FIFO address counters. Ports: clk, rst, bus (ntt_ctrl_if.master).
// Build option NTT_CTRL_BITREV_EN: store results in natural order.
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int PAIRS  = 1 << (NTT_STAGE_CNT - 1)
) (
    input  logic      clk,
    input  logic      rst,
    ntt_ctrl_if.master bus
);

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      src_cnt;
    logic [PW:0]        out_cnt;
    logic [PW:0]        out_cnt_nxt;
    logic [RD_LAT-1:0]  rd_pipe;
    logic               feed;
    logic               collect;
    logic               accept;
    logic               cnt_clr;
    logic               cnt_en;
    logic [PW-1:0]      wr_addr;
    logic [NTT_STAGE_CNT*MAX_FIFO2_ADDR_BITS-1:0] fifo2_v;

    assign feed    = (state == FEED);
    assign collect = feed || (state == DRAIN);
    // rst gating keeps strobes quiet while an abort is in progress
    assign accept  = bus.ntt_out_en && collect && !rst &&
                     (out_cnt != (PW+1)'(PAIRS));
    assign out_cnt_nxt = out_cnt + {{PW{1'b0}}, accept};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = FEED;
            FEED:  if (src_cnt == PW'(PAIRS - 1)) state_nxt = DRAIN;
            // look at the next count so done follows the last output
            DRAIN: if (out_cnt_nxt == (PW+1)'(PAIRS)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_cnt <= '0;
            out_cnt <= '0;
            rd_pipe <= '0;
        end else begin
            state   <= state_nxt;
            src_cnt <= feed ? src_cnt + 1'b1 : '0;
            out_cnt <= (state == IDLE) ? '0 : out_cnt_nxt;
            rd_pipe[0] <= feed;
            for (int i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

`ifdef NTT_CTRL_BITREV_EN
    assign wr_addr = bitrev(out_cnt[PW-1:0]);
`else
    assign wr_addr = out_cnt[PW-1:0];
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.src_rd_en = feed;
    assign bus.src_addr  = src_cnt;
    assign bus.ntt_in_en = rd_pipe[RD_LAT-1];
    assign bus.ntt_in    = rd_pipe[RD_LAT-1] ? bus.src_data : '0;
    assign bus.dst_wr_en = accept;
    assign bus.dst_addr  = accept ? wr_addr : '0;
    assign bus.dst_data  = accept ? bus.ntt_out : '0;
    assign bus.err       = bus.ntt_out_en && !accept && !rst;

    // FIFO counters restart with each job and hold while idle
    assign cnt_clr = (state == IDLE) && bus.start;
    assign cnt_en  = (state != IDLE);

    mod_cnt #(
        .MOD (MUL_STAGE_CNT - 1),
        .W   (MUL_STAGE_BITS)
    ) u_fifom (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .q   (bus.fifom_addr)
    );

    for (genvar i = 0; i < NTT_STAGE_CNT; i++) begin : g_fifo2
        mod_cnt #(
            .MOD ((i == 0) ? 0 : fifo2_size(i)),
            .W   (MAX_FIFO2_ADDR_BITS)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .en  (cnt_en),
            .q   (fifo2_v[i*MAX_FIFO2_ADDR_BITS +: MAX_FIFO2_ADDR_BITS])
        );
    end

    assign bus.fifo2_addr = fifo2_v;

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for the dual-pipelined `ntt` datapath. It streams one polynomial from a source coefficient RAM into `ntt` as coefficient pairs. It drives the shared FIFO delay-line address counters (`fifom_addr`, `fifo2_addr[]`) that every stage consumes, and it collects the transformed pairs into a destination RAM. It sits between the top-level command interface (start/done) and the `ntt` instance plus its two polynomial buffers.

## Interface
Parameters:
- `RD_LAT`, 1: source RAM read latency in cycles (1..3).
- `PAIRS`, `1<<(`NTT_STAGE_CNT-1)`: coefficient pairs per polynomial.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to transform one polynomial.
- `busy`  out  1  high from the accepted start until done.
- `done`  out  1  one-cycle pulse after the last output pair is written.
- `err`  out  1  one-cycle pulse when `ntt_out_en` is seen after `PAIRS` outputs have been collected in a job.
- `src_rd_en`  out  1  source RAM read strobe.
- `src_addr`  out  `NTT_STAGE_CNT-1`  source pair index.
- `src_data`  in  2×`DATA_WIDTH`  source pair, valid `RD_LAT` cycles after the strobe.
- `ntt_in_en`  out  1  to `ntt.in_en`.
- `ntt_in`  out  2×`DATA_WIDTH`  to `ntt.in`.
- `ntt_out_en`  in  1  from `ntt.out_en`.
- `ntt_out`  in  2×`DATA_WIDTH`  from `ntt.out`.
- `dst_wr_en`  out  1  destination RAM write strobe.
- `dst_addr`  out  `NTT_STAGE_CNT-1`  destination pair index.
- `dst_data`  out  2×`DATA_WIDTH`  destination pair.
- `fifom_addr`  out  `MUL_STAGE_BITS`  shared multiplier-FIFO address.
- `fifo2_addr`  out  `NTT_STAGE_CNT`×`MAX_FIFO2_ADDR_BITS`  per-stage reorder-FIFO address.

## Operation
FSM states and transitions:
- `IDLE`: `start` moves to `FEED`. `busy` rises the next cycle. All counters clear.
- `FEED`: `src_rd_en=1` for exactly `PAIRS` consecutive cycles, with `src_addr` running 0..`PAIRS`-1. Moves to `DRAIN` after the cycle in which `src_addr==PAIRS-1`.
- `DRAIN`: waits until the output count reaches `PAIRS`, then moves to `DONE`.
- `DONE`: `done=1` for one cycle, then returns to `IDLE`.

Datapath rules:
- `ntt_in_en` is `src_rd_en` delayed by `RD_LAT` registers. `ntt_in` is `src_data` passed through combinationally. `in_en` is therefore a contiguous block of `PAIRS` cycles, with no gaps.
- Output collection runs in `FEED`/`DRAIN` only:
  - `dst_wr_en = ntt_out_en`, `dst_data = ntt_out` (combinational).
  - The output counter increments on each `ntt_out_en` cycle and saturates at `PAIRS`.
  - `dst_addr` is derived from the counter (see Configuration).
- `ntt_out_en` in `IDLE`/`DONE`, or beyond `PAIRS` outputs, is ignored: no write, and `err` pulses.
- `start` while `busy` is ignored.

FIFO address counters:
- While `busy`, they advance every cycle, including the `RD_LAT` and drain cycles. They hold their value when idle.
- `fifom_addr` counts 0..`MUL_STAGE_CNT`-2, then wraps to 0.
- For stage i, with `HRS=1<<(NTT_STAGE_CNT-i-1)`:
  - size = `HRS-MUL_STAGE_CNT-1` if `HRS>MUL_STAGE_CNT`, else `MUL_STAGE_CNT-HRS-1`.
  - `fifo2_addr[i]` counts 0..size-1, then wraps.
  - If size ≤ 1, `fifo2_addr[i]` is held at 0.
- `fifo2_addr[0]` is unused and held at 0.

## Timing
- Reset values: every output is 0, the FSM is in `IDLE`, and all counters are 0.
- `start` at cycle t gives `src_rd_en` high over t+1..t+`PAIRS`, and `ntt_in_en` over t+1+`RD_LAT`..t+`PAIRS`+`RD_LAT`.
- `done` is asserted the cycle after the `PAIRS`-th `ntt_out_en`. `busy` falls the same cycle `done` falls.
- Simultaneous last `ntt_out_en` and `FEED` end (a very short pipeline) passes through `DRAIN` for one cycle. No output is lost.
- Reset mid-job aborts immediately: no `done` pulse, and in-flight `ntt` data is discarded.

## Configuration
- `NTT_CTRL_BITREV_EN` defined: `dst_addr` = bit-reversal of the output counter over `NTT_STAGE_CNT-1` bits, so results are stored in natural order.
- Not defined: `dst_addr` = output counter, so results are stored in the pipeline's bit-reversed order.

## Structure
- The shared package holds:
  - the FSM state enum (`IDLE`, `FEED`, `DRAIN`, `DONE`);
  - the function computing the fifo2 size per stage (also used by `ntt` instantiation checks);
  - the `bitrev` function.
- One sub-module, `mod_cnt`: a parameterized wrapping counter with enable. It is instantiated once for `fifom_addr` and once per stage in a generate loop for `fifo2_addr`.

## Test plan
- Reset then idle 20 cycles → all outputs 0, `fifom_addr` stays 0.
- `start` with `RD_LAT=1` and a ramp source (pair k = {2k, 2k+1}) → `src_rd_en` high exactly `PAIRS` cycles, `ntt_in_en` contiguous starting 2 cycles after `start`, `ntt_in` equal to the ramp, and `done` one cycle after the 128th output when `PAIRS=128`.
- Model `ntt_out_en` as a 40-cycle delay of `ntt_in_en`, run with and without `NTT_CTRL_BITREV_EN` → first write goes to `dst_addr` 0, second write to 64 (bitrev, `PAIRS=128`) vs 1 (natural).
- `start` pulsed again mid-`FEED` → ignored, exactly one `done`.
- Inject one extra `ntt_out_en` after `done` → `err` pulses once, and there is no `dst_wr_en`.
- Assert `rst` during `DRAIN` → all outputs 0 the same cycle, no `done`, and a following `start` completes normally.
